// File: rtl/ni_pkg.sv
// Shared FSM state type and AXI write-response codes for the NI transmit sequencer.
package ni_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CAP_ADDR  = 3'd1,
    WAIT_DATA = 3'd2,
    CAP_DATA  = 3'd3,
    ISSUE     = 3'd4,
    RESP      = 3'd5
  } ni_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // SLVERR/DECERR are failures; OKAY/EXOKAY are successes.
  function automatic logic resp_is_err(input logic [1:0] resp);
    case (resp)
      AXI_RESP_OKAY, AXI_RESP_EXOKAY:   return 1'b0;
      AXI_RESP_SLVERR, AXI_RESP_DECERR: return 1'b1;
      default:                          return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ni_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over a same-cycle increment.
module ni_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/ni_tx_sequencer.sv
// Drains two-word packets (address, data) from the NI TX FIFO into AXI4-lite single writes.
// Optional re-issue of failed writes is built when NI_RETRY_EN is defined.
module ni_tx_sequencer
  import ni_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned MAX_RETRY = 3
) (
  input  logic                aclk,
  input  logic                arestn,
  input  logic                enable,
  input  logic                cnt_clr,
  input  logic                fifo_empty,
  output logic                fifo_rd_en,
  input  logic [DATA_W-1:0]   fifo_rd_data,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready,
  output logic                busy,
  output logic                err_pulse,
  output logic [1:0]          err_resp,
  output logic [CNT_W-1:0]    tx_count,
  output logic [CNT_W-1:0]    err_count
);

  localparam int unsigned STRB_W = DATA_W / 8;

  ni_state_e r_state, w_state_nxt;

  logic [ADDR_W-1:0] r_addr_q;
  logic [DATA_W-1:0] r_data_q;
  logic              r_awvalid, r_wvalid;
  logic              r_err_pulse;
  logic [1:0]        r_err_resp;

  logic w_fifo_rd_en;
  logic w_cap_addr, w_cap_data;
  logic w_awvalid_nxt, w_wvalid_nxt;
  logic w_tx_inc, w_err_inc;
  logic w_new_pkt, w_retry, w_can_retry;

  // State register
  always_ff @(posedge aclk or negedge arestn) begin
    if (!arestn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and control decode
  always_comb begin
    w_state_nxt   = r_state;
    w_fifo_rd_en  = 1'b0;
    w_cap_addr    = 1'b0;
    w_cap_data    = 1'b0;
    w_awvalid_nxt = r_awvalid;
    w_wvalid_nxt  = r_wvalid;
    w_tx_inc      = 1'b0;
    w_err_inc     = 1'b0;
    w_new_pkt     = 1'b0;
    w_retry       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (enable && !fifo_empty) begin
          w_fifo_rd_en = 1'b1;
          w_new_pkt    = 1'b1;
          w_state_nxt  = CAP_ADDR;
        end
      end
      CAP_ADDR: begin
        w_cap_addr = 1'b1;
        if (!fifo_empty) begin
          w_fifo_rd_en = 1'b1;
          w_state_nxt  = CAP_DATA;
        end else begin
          w_state_nxt = WAIT_DATA;
        end
      end
      WAIT_DATA: begin
        if (!fifo_empty) begin
          w_fifo_rd_en = 1'b1;
          w_state_nxt  = CAP_DATA;
        end
      end
      CAP_DATA: begin
        w_cap_data    = 1'b1;
        w_awvalid_nxt = 1'b1;
        w_wvalid_nxt  = 1'b1;
        w_state_nxt   = ISSUE;
      end
      ISSUE: begin
        // Each valid drops after its own handshake; a low valid means that channel is done.
        if (r_awvalid && awready) w_awvalid_nxt = 1'b0;
        if (r_wvalid && wready)   w_wvalid_nxt  = 1'b0;
        if ((!r_awvalid || awready) && (!r_wvalid || wready)) begin
          w_state_nxt = RESP;
        end
      end
      RESP: begin
        if (bvalid) begin
          if (!resp_is_err(bresp)) begin
            w_tx_inc    = 1'b1;
            w_state_nxt = IDLE;
          end else if (w_can_retry) begin
            w_retry       = 1'b1;
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
            w_state_nxt   = ISSUE;
          end else begin
            w_err_inc   = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Packet capture, AXI valids and error reporting
  always_ff @(posedge aclk or negedge arestn) begin
    if (!arestn) begin
      r_addr_q    <= '0;
      r_data_q    <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_resp  <= 2'b00;
    end else begin
      if (w_cap_addr) r_addr_q <= fifo_rd_data[ADDR_W-1:0];
      if (w_cap_data) r_data_q <= fifo_rd_data;
      r_awvalid   <= w_awvalid_nxt;
      r_wvalid    <= w_wvalid_nxt;
      r_err_pulse <= w_err_inc;
      if (w_err_inc) r_err_resp <= bresp;
    end
  end

`ifdef NI_RETRY_EN
  localparam int unsigned RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  logic [RETRY_W-1:0] r_retry_cnt;

  // Re-issues used by the current packet; restarts with every new packet
  always_ff @(posedge aclk or negedge arestn) begin
    if (!arestn) begin
      r_retry_cnt <= '0;
    end else if (w_new_pkt) begin
      r_retry_cnt <= '0;
    end else if (w_retry) begin
      r_retry_cnt <= r_retry_cnt + RETRY_W'(1);
    end
  end

  assign w_can_retry = (r_retry_cnt < RETRY_W'(MAX_RETRY));
`else
  logic w_unused_retry;

  assign w_can_retry    = 1'b0;
  assign w_unused_retry = w_retry ^ w_new_pkt ^ (MAX_RETRY != 0);
`endif

  ni_sat_counter #(.CNT_W(CNT_W)) u_tx_cnt (
    .clk     (aclk),
    .rst_n   (arestn),
    .i_inc   (w_tx_inc),
    .i_clr   (cnt_clr),
    .o_count (tx_count)
  );

  ni_sat_counter #(.CNT_W(CNT_W)) u_err_cnt (
    .clk     (aclk),
    .rst_n   (arestn),
    .i_inc   (w_err_inc),
    .i_clr   (cnt_clr),
    .o_count (err_count)
  );

  assign fifo_rd_en = w_fifo_rd_en;
  assign awaddr     = r_addr_q;
  assign awvalid    = r_awvalid;
  assign wdata      = r_data_q;
  assign wstrb      = {STRB_W{1'b1}};
  assign wvalid     = r_wvalid;
  assign bready     = (r_state == RESP);
  assign busy       = (r_state != IDLE);
  assign err_pulse  = r_err_pulse;
  assign err_resp   = r_err_resp;

endmodule

// File: tb/tb_ni_tx_sequencer.sv
// Directed bench for ni_tx_sequencer: FIFO model, AXI slave model and write scoreboard.
module tb_ni_tx_sequencer;
  import ni_pkg::*;

  localparam int unsigned CNT_W = 4;
`ifdef NI_RETRY_EN
  localparam int EXP_ISSUES = 4;
`else
  localparam int EXP_ISSUES = 1;
`endif

  logic             aclk = 1'b0;
  logic             arestn, enable, cnt_clr;
  logic             fifo_empty, fifo_rd_en;
  logic [31:0]      fifo_rd_data;
  logic [31:0]      awaddr, wdata;
  logic [3:0]       wstrb;
  logic             awvalid, awready, wvalid, wready;
  logic [1:0]       bresp;
  logic             bvalid, bready, busy, err_pulse;
  logic [1:0]       err_resp;
  logic [CNT_W-1:0] tx_count, err_count;

  int n_vec = 0;
  int n_err = 0;
  int n_aw_hs = 0;
  int n_underflow = 0;

  always #5 aclk = ~aclk;

  ni_tx_sequencer #(.ADDR_W(32), .DATA_W(32), .CNT_W(CNT_W), .MAX_RETRY(3)) dut (
    .aclk(aclk), .arestn(arestn), .enable(enable), .cnt_clr(cnt_clr),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .busy(busy), .err_pulse(err_pulse), .err_resp(err_resp),
    .tx_count(tx_count), .err_count(err_count)
  );

  // TX FIFO model: registered read data one cycle after the pop
  logic [31:0] fifo_mem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge aclk) begin
    if (fifo_rd_en && !fifo_empty) begin
      fifo_rd_data <= fifo_mem[rd_ptr % 64];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  // AXI slave model with programmable ready latency and response code
  int          aw_delay, w_delay, aw_cnt, w_cnt;
  logic [1:0]  resp_code;
  logic        aw_seen, w_seen, a_done, d_done;
  assign awready = awvalid && (aw_cnt >= aw_delay);
  assign wready  = wvalid && (w_cnt >= w_delay);
  assign bresp   = resp_code;
  always @(posedge aclk or negedge arestn) begin
    if (!arestn) begin
      aw_cnt <= 0; w_cnt <= 0; aw_seen <= 1'b0; w_seen <= 1'b0; bvalid <= 1'b0;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      a_done = aw_seen || (awvalid && awready);
      d_done = w_seen || (wvalid && wready);
      if (bvalid && bready) begin
        bvalid <= 1'b0;
      end else if (!bvalid && a_done && d_done) begin
        bvalid <= 1'b1;
        a_done = 1'b0;
        d_done = 1'b0;
      end
      aw_seen <= a_done;
      w_seen  <= d_done;
    end
  end

  logic [31:0] exp_aw [$];
  logic [31:0] exp_w  [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: each AW/W handshake pops the oldest expected write
  always @(negedge aclk) begin
    if (arestn) begin
      if (awvalid && awready) begin
        n_aw_hs++;
        if (exp_aw.size() == 0) chk("aw_unexpected", 64'(awaddr), 64'hFFFF_FFFF_FFFF_FFFF);
        else                    chk("awaddr", 64'(awaddr), 64'(exp_aw.pop_front()));
      end
      if (wvalid && wready) begin
        if (exp_w.size() == 0) chk("w_unexpected", 64'(wdata), 64'hFFFF_FFFF_FFFF_FFFF);
        else                   chk("wdata", 64'(wdata), 64'(exp_w.pop_front()));
      end
      if (fifo_rd_en && fifo_empty) n_underflow++;
    end
  end

  task automatic push(input logic [31:0] w);
    fifo_mem[wr_ptr % 64] = w;
    wr_ptr++;
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      exp_aw.push_back(a);
      exp_w.push_back(d);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] d, input int n);
    push(a);
    push(d);
    expect_wr(a, d, n);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 300) begin
      @(negedge aclk);
      k++;
    end
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic run_pkt(input string tag, output int n_aw, output int n_w,
                         output int n_ovl, output int n_ep);
    int k = 0;
    n_aw = 0; n_w = 0; n_ovl = 0; n_ep = 0;
    while (!busy && k < 50) begin
      @(negedge aclk);
      k++;
    end
    chk({tag, "_start"}, 64'(busy), 64'd1);
    k = 0;
    while (busy && k < 300) begin
      n_aw  += int'(awvalid);
      n_w   += int'(wvalid);
      n_ep  += int'(err_pulse);
      if (bready && (awvalid || wvalid)) n_ovl++;
      @(negedge aclk);
      k++;
    end
    n_ep += int'(err_pulse);
    chk({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_aw, n_w, n_ovl, n_ep, hs0, cnt, c;
    int pops [$];
    arestn = 1'b0; enable = 1'b0; cnt_clr = 1'b0;
    aw_delay = 0; w_delay = 0; resp_code = AXI_RESP_OKAY;

    repeat (3) @(negedge aclk);
    chk("rst_ctrl", 64'({fifo_rd_en, awvalid, wvalid, bready, busy, err_pulse}), 64'd0);
    chk("rst_err_resp", 64'(err_resp), 64'd0);
    chk("rst_counts", 64'({tx_count, err_count}), 64'd0);
    chk("rst_addr_data", {awaddr, wdata}, 64'd0);
    chk("rst_wstrb", 64'(wstrb), 64'hF);
    @(posedge aclk); #1 arestn = 1'b1;

    // Single packet, best-case latency; nothing moves while enable is low
    send(32'h1000_0000, 32'hDEAD_BEEF, 1);
    cnt = 0;
    repeat (3) begin @(negedge aclk); cnt += int'(fifo_rd_en) + int'(busy); end
    chk("t1_enable_gate", 64'(cnt), 64'd0);
    @(posedge aclk); #1 enable = 1'b1;
    @(negedge aclk); chk("t1_cyc0", 64'({fifo_rd_en, busy, awvalid}), 64'h4);
    @(negedge aclk); chk("t1_cyc1", 64'({fifo_rd_en, busy, awvalid}), 64'h6);
    @(negedge aclk); chk("t1_cyc2", 64'({fifo_rd_en, busy, awvalid}), 64'h2);
    @(negedge aclk); chk("t1_cyc3", 64'({busy, awvalid, wvalid}), 64'h7);
    chk("t1_awaddr", 64'(awaddr), 64'h1000_0000);
    chk("t1_wdata", 64'(wdata), 64'hDEAD_BEEF);
    wait_idle("t1");
    chk("t1_tx_count", 64'(tx_count), 64'd1);

    // Address word alone, data 20 cycles later; enable dropped mid-packet
    push(32'h0000_2000);
    expect_wr(32'h0000_2000, 32'h1234_5678, 1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      cnt += int'(awvalid);
      if (i == 5) enable = 1'b0;
    end
    chk("t2_no_issue", 64'(cnt), 64'd0);
    chk("t2_waiting", 64'(busy), 64'd1);
    push(32'h1234_5678);
    wait_idle("t2");
    chk("t2_tx_count", 64'(tx_count), 64'd2);
    enable = 1'b1;

    // AW ready 5 cycles late, W immediate
    aw_delay = 5;
    send(32'h3000_0004, 32'hA5A5_0001, 1);
    run_pkt("t3a", n_aw, n_w, n_ovl, n_ep);
    chk("t3a_aw_cycles", 64'(n_aw), 64'd6);
    chk("t3a_w_cycles", 64'(n_w), 64'd1);
    chk("t3a_resp_early", 64'(n_ovl), 64'd0);
    chk("t3a_tx_count", 64'(tx_count), 64'd3);
    aw_delay = 0;

    // W ready 3 cycles late, AW immediate
    w_delay = 3;
    send(32'h3000_0008, 32'hA5A5_0002, 1);
    run_pkt("t3b", n_aw, n_w, n_ovl, n_ep);
    chk("t3b_aw_cycles", 64'(n_aw), 64'd1);
    chk("t3b_w_cycles", 64'(n_w), 64'd4);
    chk("t3b_resp_early", 64'(n_ovl), 64'd0);
    chk("t3b_tx_count", 64'(tx_count), 64'd4);
    w_delay = 0;

    // EXOKAY counts as success
    resp_code = AXI_RESP_EXOKAY;
    send(32'h4000_0000, 32'h0000_00EE, 1);
    run_pkt("t4", n_aw, n_w, n_ovl, n_ep);
    chk("t4_counts", 64'({tx_count, err_count}), 64'h50);

    // SLVERR every time
    resp_code = AXI_RESP_SLVERR;
    hs0 = n_aw_hs;
    send(32'h5000_0010, 32'hBAD0_0001, EXP_ISSUES);
    run_pkt("t5", n_aw, n_w, n_ovl, n_ep);
    chk("t5_issues", 64'(n_aw_hs - hs0), 64'(EXP_ISSUES));
    chk("t5_err_pulses", 64'(n_ep), 64'd1);
    chk("t5_err_count", 64'(err_count), 64'd1);
    chk("t5_err_resp", 64'(err_resp), 64'h2);
    chk("t5_tx_count", 64'(tx_count), 64'd5);

    // DECERR every time
    resp_code = AXI_RESP_DECERR;
    hs0 = n_aw_hs;
    send(32'h5000_0020, 32'hBAD0_0002, EXP_ISSUES);
    run_pkt("t6", n_aw, n_w, n_ovl, n_ep);
    chk("t6_issues", 64'(n_aw_hs - hs0), 64'(EXP_ISSUES));
    chk("t6_err_pulses", 64'(n_ep), 64'd1);
    chk("t6_err_state", 64'({err_count, err_resp}), 64'hB);
    resp_code = AXI_RESP_OKAY;

    // Reset asserted while the write is outstanding in ISSUE
    aw_delay = 10; w_delay = 10;
    push(32'h6000_0000);
    push(32'h6666_6666);
    c = 0;
    while (!awvalid && c < 20) begin @(negedge aclk); c++; end
    chk("t7_in_issue", 64'(awvalid), 64'd1);
    #2 arestn = 1'b0;
    #1;
    chk("t7_rst_ctrl", 64'({fifo_rd_en, awvalid, wvalid, bready, busy, err_pulse}), 64'd0);
    chk("t7_rst_state", 64'({tx_count, err_count, err_resp}), 64'd0);
    chk("t7_rst_addr_data", {awaddr, wdata}, 64'd0);
    repeat (2) @(negedge aclk);
    @(posedge aclk); #1 arestn = 1'b1;
    aw_delay = 0; w_delay = 0;
    send(32'h7000_0000, 32'h7777_7777, 1);
    run_pkt("t7", n_aw, n_w, n_ovl, n_ep);
    chk("t7_counts", 64'({tx_count, err_count}), 64'h10);

    // Back-to-back packets: next pop the cycle after the B handshake
    @(posedge aclk); #1;
    send(32'h8000_0000, 32'h8888_0000, 1);
    send(32'h8000_0004, 32'h8888_0004, 1);
    for (int i = 0; i < 30; i++) begin
      @(negedge aclk);
      if (fifo_rd_en) pops.push_back(i);
    end
    chk("t8_pop_count", 64'(pops.size()), 64'd4);
    if (pops.size() >= 3) chk("t8_second_pop", 64'(pops[2] - pops[0]), 64'd5);
    wait_idle("t8");
    chk("t8_tx_count", 64'(tx_count), 64'd3);

    // Saturate tx_count, then one more write
    for (int k = 0; k < 12; k++) begin
      send(32'h9000_0000 + 32'(k), 32'h9900_0000 + 32'(k), 1);
      run_pkt("t8_sat", n_aw, n_w, n_ovl, n_ep);
    end
    chk("t8_tx_full", 64'(tx_count), 64'hF);
    send(32'h9100_0000, 32'h9911_1111, 1);
    run_pkt("t8_over", n_aw, n_w, n_ovl, n_ep);
    chk("t8_tx_hold", 64'(tx_count), 64'hF);

    // cnt_clr coincident with the B OKAY handshake
    send(32'hA000_0000, 32'hAAAA_AAAA, 1);
    c = 0;
    while (!(bvalid && bready) && c < 50) begin @(negedge aclk); c++; end
    chk("t9_b_hs", 64'(bvalid && bready), 64'd1);
    cnt_clr = 1'b1;
    @(posedge aclk); #1 cnt_clr = 1'b0;
    @(negedge aclk);
    chk("t9_tx_cleared", 64'(tx_count), 64'd0);
    wait_idle("t9");

    chk("sb_drained", 64'(exp_aw.size() + exp_w.size()), 64'd0);
    chk("no_underflow_pop", 64'(n_underflow), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
